// File: rtl/usb_hub_upstream_arbiter.sv
// usb_hub_upstream_arbiter
// Round-robin arbiter for the hub's single upstream transmit path. One port is
// granted at a time and keeps the grant until it signals end-of-packet; every
// release is followed by a fixed turnaround gap, and new grants are deferred
// while the host is driving downstream traffic.
// Optional feature macro: USB_HUB_ARB_TIMEOUT_EN -- revokes a grant held for
// TIMEOUT_CYCLES cycles and pulses timeout_pulse. Without it timeout_pulse is 0.

module usb_hub_upstream_arbiter #(
    parameter int NUM_USB_DEVICES = 2,
    parameter int GAP_CYCLES      = 4,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int IDX_W = (NUM_USB_DEVICES > 1) ? $clog2(NUM_USB_DEVICES) : 1
) (
    input  logic                       hi_clock,
    input  logic                       reset,
    input  logic [NUM_USB_DEVICES-1:0] dev_req,
    input  logic [NUM_USB_DEVICES-1:0] dev_eop,
    input  logic                       host_busy,
    output logic [NUM_USB_DEVICES-1:0] dev_grant,
    output logic                       grant_valid,
    output logic [IDX_W-1:0]           grant_idx,
    output logic [1:0]                 arb_state,
    output logic                       timeout_pulse
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    // Pointer arithmetic is done one bit wider so last+k never overflows
    // before the explicit wrap against N.
    localparam logic [IDX_W:0]   N_W      = (IDX_W+1)'(NUM_USB_DEVICES);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_USB_DEVICES - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     last;
    logic [GAP_W-1:0]     gap_cnt;

    logic                       sel_found;
    logic [IDX_W-1:0]           sel_idx;
    logic [NUM_USB_DEVICES-1:0] sel_onehot;
    logic                       eop_hit;

`ifdef USB_HUB_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign timeout_pulse = 1'b0;
`endif

    // Round-robin pick: scan last+1 .. last+N (mod N); scanning from the far
    // end down lets the nearest requester overwrite the others.
    always_comb begin
        logic [IDX_W:0] sum;
        sel_found = 1'b0;
        sel_idx   = '0;
        sum       = '0;
        for (int k = NUM_USB_DEVICES; k >= 1; k--) begin
            sum = {1'b0, last} + (IDX_W+1)'(k);
            if (sum >= N_W)
                sum = sum - N_W;
            if (dev_req[sum[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = sum[IDX_W-1:0];
            end
        end
    end

    // Decode the selected index into the one-hot grant vector, one bit per port.
    for (genvar i = 0; i < NUM_USB_DEVICES; i++) begin : g_onehot
        assign sel_onehot[i] = (sel_idx == IDX_W'(i));
    end

    // Only the owner's eop counts; dev_grant is one-hot so masking isolates it.
    assign eop_hit   = |(dev_eop & dev_grant);
    assign arb_state = state;

    // Arbiter FSM: grant in IDLE, hold in ACTIVE, fixed turnaround in GAP.
    always_ff @(posedge hi_clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dev_grant   <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last        <= LAST_RST;
            gap_cnt     <= '0;
`ifdef USB_HUB_ARB_TIMEOUT_EN
            to_cnt        <= '0;
            timeout_pulse <= 1'b0;
`endif
        end else begin
`ifdef USB_HUB_ARB_TIMEOUT_EN
            timeout_pulse <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!host_busy && sel_found) begin
                        dev_grant   <= sel_onehot;
                        grant_valid <= 1'b1;
                        grant_idx   <= sel_idx;
                        last        <= sel_idx;
                        state       <= ACTIVE;
`ifdef USB_HUB_ARB_TIMEOUT_EN
                        to_cnt      <= '0;
`endif
                    end
                end
                ACTIVE: begin
                    // An eop on the timeout edge wins: normal release, no pulse.
                    if (eop_hit) begin
                        dev_grant   <= '0;
                        grant_valid <= 1'b0;
                        gap_cnt     <= GAP_LOAD;
                        state       <= GAP;
                    end
`ifdef USB_HUB_ARB_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        dev_grant     <= '0;
                        grant_valid   <= 1'b0;
                        gap_cnt       <= GAP_LOAD;
                        state         <= GAP;
                        timeout_pulse <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/usb_hub_upstream_arbiter.md
Name: usb_hub_upstream_arbiter

Overview:
- Shares the single upstream (hub-to-host) transmit path among NUM_USB_DEVICES downstream ports.
- Grants one requesting port at a time, round-robin, and holds the grant until that port signals end-of-packet.
- Enforces a bus turnaround gap after each packet and defers new grants while the host side is driving downstream traffic.
- Sits between the per-port packet receivers and the upstream transmit mux inside usb_hub_top, clocked on hi_clock.

Parameters:
- NUM_USB_DEVICES, 2: number of downstream ports; legal range ≥1.
- GAP_CYCLES, 4: idle hi_clock cycles after each grant release; legal range ≥1.
- TIMEOUT_CYCLES, 1024: maximum cycles a grant may be held when the timeout feature is compiled in; legal range ≥2.
- Derived IDX_W = max(1, $clog2(NUM_USB_DEVICES)).

Ports:
- hi_clock  input  1  sole clock for the block.
- reset  input  1  asynchronous, active-high reset.
- dev_req  input  NUM_USB_DEVICES  per-port level request: port has a packet for the host.
- dev_eop  input  NUM_USB_DEVICES  per-port single-cycle pulse: granted port finished its packet.
- host_busy  input  1  high while host-to-device traffic occupies the link.
- dev_grant  output  NUM_USB_DEVICES  one-hot grant, registered.
- grant_valid  output  1  equals |dev_grant.
- grant_idx  output  IDX_W  binary index of the granted port; holds the last value when there is no grant.
- arb_state  output  2  debug copy of FSM state: IDLE=0, ACTIVE=1, GAP=2.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by timeout.

Behaviour:
- Reset (async, takes effect immediately): dev_grant=0, grant_valid=0, grant_idx=0, arb_state=IDLE, timeout_pulse=0, gap counter=0, timeout counter=0, round-robin pointer last=NUM_USB_DEVICES-1, so port 0 has first priority.
- All outputs are registered. No combinational paths from inputs to outputs.
- IDLE:
  - On a rising edge where host_busy=0 and |dev_req=1, select the first requesting port scanning last+1, last+2, … modulo N.
  - On that same edge: set the one-hot dev_grant, grant_valid=1, grant_idx=sel, last=sel, state→ACTIVE.
  - Latency: request sampled at edge k gives grant visible after edge k, i.e. one cycle from request assertion.
  - host_busy=1 or no requests: stay IDLE.
- ACTIVE:
  - The grant is held regardless of dev_req or host_busy.
  - Only dev_eop[grant_idx] ends the grant; eop bits of other ports are ignored.
  - On a qualifying eop edge: dev_grant=0, grant_valid=0, load gap counter with GAP_CYCLES-1, state→GAP.
  - A request from the same port during ACTIVE does not extend the grant.
- GAP:
  - No grant is issued. The counter decrements each cycle.
  - At counter=0, state→IDLE, so exactly GAP_CYCLES cycles are spent in GAP.
  - Requests arriving during GAP are not lost, because dev_req is level-sensitive; they are evaluated in IDLE.
- Fairness: after port i is served, port i has the lowest priority. For N=1, the single port is re-granted after every gap.
- An eop coinciding with a timeout edge is treated as a normal eop; timeout_pulse stays 0.
- grant_idx width is IDX_W. The modulo wrap for the pointer is explicit, so non-power-of-two N is handled.
- Reset asserted mid-ACTIVE drops the grant immediately; there is no gap after reset.

Optional Feature:
- Macro: USB_HUB_ARB_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - If it reaches TIMEOUT_CYCLES-1 without a qualifying eop, on the next edge: release the grant, pulse timeout_pulse=1 for one cycle, enter GAP as for a normal eop.
  - Total grant length on timeout is TIMEOUT_CYCLES cycles.
- Undefined:
  - No counter logic is built; timeout_pulse is tied to 0.
  - A grant is held indefinitely until eop or reset.

Test Plan:
- Reset with dev_req=2'b11 held → all outputs 0 during reset. First edge after release: dev_grant=2'b01, grant_idx=0.
- Single requester dev_req=2'b10, host_busy=0 → dev_grant=2'b10 one cycle later. dev_eop=2'b10 → grant drops next edge, arb_state=2 for exactly 4 cycles, then 0.
- Both ports requesting continuously, eop issued 3 cycles after each grant → grant order 0,1,0,1. Each grant is separated by a 4-cycle gap.
- host_busy=1 with dev_req=2'b01 for 10 cycles → no grant. Grant appears 1 cycle after host_busy falls. Raising host_busy during ACTIVE leaves the grant held.
- Port 0 granted, dev_eop=2'b10 pulsed → ignored and grant held. dev_eop=2'b01 → released.
- USB_HUB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, port 0 never sends eop → grant held for 16 cycles, timeout_pulse high for 1 cycle, GAP entered, then port 1 is granted if requesting. Same stimulus with the macro undefined → grant persists and timeout_pulse stays 0.
